llc_update_seq: RTL and testbench

Parametrised, sequenced successor of the LLC single-cycle update stage. Accepts one update command per handshake: way write-back (UPDATE), set flush (FLUSH) or set reset (RST). It snapshots the set buffers on acceptance and drives the LLC memory write interface from registered outputs. Reset/flush sweeps cover WAYS ways in groups of WR_PORTS per cycle, which serialises large sets over a narrower write-enable fabric. Sits between the LLC control FSM and the tag/state/line/evict-way memories.

---
 rtl/llc_update_seq.sv | 211 +++++++++++++++++++++
 tb/tb_llc_update_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_update_seq.sv
// llc_update_seq
// Sequenced LLC update stage. It accepts one command per handshake:
// UPDATE writes back one way, FLUSH invalidates eligible ways of a set,
// RST invalidates every way of a set, and NOP only completes.
// On acceptance the command and the relevant set-buffer contents are captured.
// Reset and flush sweeps then visit WAYS/WR_PORTS groups, one group per
// non-stalled cycle.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready        command handshake (ready only in IDLE)
//   req_op                     0 UPDATE, 1 FLUSH, 2 RST, 3 NOP
//   req_way, req_evict_way     target way / evict-way value for UPDATE
//   req_update_evict_way       UPDATE also writes the evict way
//   *_buf                      per-way set buffers, way i at [i*W +: W]
//   wr_stall                   memory write port busy this cycle
//   wr_en, wr_way              single-way write strobe and its way
//   wr_rst_flush               per-way invalidate strobes
//   wr_en_evict_way            evict-way write strobe
//   wr_data_*                  write data
//   incr_rst_flush_stalled_set one-cycle pulse at sweep end
//   done                       one-cycle pulse when a command completes
module llc_update_seq #(
  parameter int WAYS      = 16,
  parameter int WR_PORTS  = 4,
  parameter int WAY_W     = $clog2(WAYS),
  parameter int STATE_W   = 3,
  parameter int TAG_W     = 20,
  parameter int LINE_W    = 128,
  parameter int SHARERS_W = 16,
  parameter int OWNER_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [WAY_W-1:0]          req_way,
  input  logic                      req_update_evict_way,
  input  logic [WAY_W-1:0]          req_evict_way,
  input  logic [WAYS*STATE_W-1:0]   states_buf,
  input  logic [WAYS-1:0]           hprots_buf,
  input  logic [WAYS-1:0]           dirty_bits_buf,
  input  logic [WAYS*TAG_W-1:0]     tags_buf,
  input  logic [WAYS*LINE_W-1:0]    lines_buf,
  input  logic [WAYS*SHARERS_W-1:0] sharers_buf,
  input  logic [WAYS*OWNER_W-1:0]   owners_buf,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [WAY_W-1:0]          wr_way,
  output logic [WAYS-1:0]           wr_rst_flush,
  output logic                      wr_en_evict_way,
  output logic [STATE_W-1:0]        wr_data_state,
  output logic [TAG_W-1:0]          wr_data_tag,
  output logic [LINE_W-1:0]         wr_data_line,
  output logic [SHARERS_W-1:0]      wr_data_sharers,
  output logic [OWNER_W-1:0]        wr_data_owner,
  output logic [WAY_W-1:0]          wr_data_evict_way,
  output logic                      wr_data_hprot,
  output logic                      wr_data_dirty_bit,
  output logic                      incr_rst_flush_stalled_set,
  output logic                      done
);

  localparam int G   = WAYS / WR_PORTS;
  localparam int G_W = (G > 1) ? $clog2(G) : 1;
  localparam logic [G_W-1:0] G_LAST = G_W'(G - 1);

  localparam logic [1:0] OP_UPDATE = 2'd0;
  localparam logic [1:0] OP_FLUSH  = 2'd1;
  localparam logic [1:0] OP_RST    = 2'd2;
  localparam logic [1:0] OP_NOP    = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_UPD   = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;

  localparam logic [STATE_W-1:0] ST_INVALID = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_VALID   = STATE_W'(1);
  localparam logic               HPROT_DATA = 1'b1;

  logic [1:0]      fsm;
  logic [G_W-1:0]  g;
  logic            sweep_flush;
  logic            upd_nop;
  logic            upd_evict;
  logic [WAYS-1:0] flush_elig;

  logic [WAYS-1:0] elig_now;
  logic [WAYS-1:0] grp_mask;
  logic            accept;
  logic            go;
  logic            sweep_last;

  assign req_ready  = (fsm == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign go         = !wr_stall;
  assign sweep_last = (fsm == S_SWEEP) && (g == G_LAST);

  // Flush eligibility is evaluated from the live buffers.
  // Only the accept-cycle value is kept.
  always_comb begin
    elig_now = '0;
    for (int i = 0; i < WAYS; i++) begin
      elig_now[i] = (states_buf[i*STATE_W +: STATE_W] == ST_VALID) &&
                    (hprots_buf[i] == HPROT_DATA);
    end
  end

  always_comb begin
    grp_mask = '0;
    for (int i = 0; i < WAYS; i++) begin
      grp_mask[i] = ((i / WR_PORTS) == int'(g));
    end
  end

  // NOTE: state and data are registered. The strobes are a decode of the
  // registered state, gated by wr_stall in the same cycle. A busy write
  // port therefore suppresses exactly the cycle it is busy, and the
  // command resumes unchanged afterwards.
  assign wr_en                      = go && (fsm == S_UPD) && !upd_nop;
  assign wr_en_evict_way            = go && (((fsm == S_UPD) && upd_evict) ||
                                             (sweep_last && !sweep_flush));
  assign wr_rst_flush               = (go && (fsm == S_SWEEP)) ?
                                      (grp_mask & (sweep_flush ? flush_elig : {WAYS{1'b1}})) :
                                      '0;
  assign incr_rst_flush_stalled_set = go && sweep_last;
  assign done                       = go && ((fsm == S_UPD) || sweep_last);

  // NOTE: non-blocking assignments throughout, so every register samples
  // pre-edge values. The captured write-data registers are also reset,
  // because they drive module outputs that must read 0 under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm               <= S_IDLE;
      g                 <= '0;
      sweep_flush       <= 1'b0;
      upd_nop           <= 1'b0;
      upd_evict         <= 1'b0;
      flush_elig        <= '0;
      wr_way            <= '0;
      wr_data_state     <= '0;
      wr_data_tag       <= '0;
      wr_data_line      <= '0;
      wr_data_sharers   <= '0;
      wr_data_owner     <= '0;
      wr_data_evict_way <= '0;
      wr_data_hprot     <= 1'b0;
      wr_data_dirty_bit <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_UPDATE: begin
                fsm               <= S_UPD;
                upd_nop           <= 1'b0;
                upd_evict         <= req_update_evict_way;
                wr_way            <= req_way;
                wr_data_state     <= states_buf[int'(req_way)*STATE_W +: STATE_W];
                wr_data_tag       <= tags_buf[int'(req_way)*TAG_W +: TAG_W];
                wr_data_line      <= lines_buf[int'(req_way)*LINE_W +: LINE_W];
                wr_data_sharers   <= sharers_buf[int'(req_way)*SHARERS_W +: SHARERS_W];
                wr_data_owner     <= owners_buf[int'(req_way)*OWNER_W +: OWNER_W];
                wr_data_hprot     <= hprots_buf[req_way];
                wr_data_dirty_bit <= dirty_bits_buf[req_way];
                wr_data_evict_way <= req_evict_way;
              end
              OP_NOP: begin
                fsm       <= S_UPD;
                upd_nop   <= 1'b1;
                upd_evict <= 1'b0;
              end
              default: begin
                // FLUSH and RST share the sweep and differ only in the mask.
                fsm               <= S_SWEEP;
                g                 <= '0;
                sweep_flush       <= (req_op == OP_FLUSH);
                flush_elig        <= elig_now;
                wr_data_state     <= ST_INVALID;
                wr_data_dirty_bit <= 1'b0;
                wr_data_sharers   <= '0;
                wr_data_evict_way <= '0;
              end
            endcase
          end
        end
        S_UPD: begin
          if (go) fsm <= S_IDLE;
        end
        S_SWEEP: begin
          if (go) begin
            if (g == G_LAST) begin
              g   <= '0;
              fsm <= S_IDLE;
            end else begin
              g <= g + G_W'(1);
            end
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // OP_RST is named for readability of the decode above.
  // It is implied by the default branch.
  logic unused_op_rst;
  assign unused_op_rst = (OP_RST == 2'd2);

endmodule

// File: tb/tb_llc_update_seq.sv
module tb_llc_update_seq;

  localparam logic [2:0] INV = 3'd0;
  localparam logic [2:0] VAL = 3'd1;
  localparam logic [2:0] SHR = 3'd2;
  localparam logic DATA  = 1'b1;
  localparam logic INSTR = 1'b0;
  localparam logic [1:0] OP_UPDATE = 2'd0, OP_FLUSH = 2'd1, OP_RST = 2'd2, OP_NOP = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  logic [1:0] req_op;
  logic [3:0] req_way, req_evict_way;
  logic req_update_evict_way;
  logic [47:0] states_buf;
  logic [15:0] hprots_buf, dirty_bits_buf;
  logic [319:0] tags_buf;
  logic [2047:0] lines_buf;
  logic [255:0] sharers_buf;
  logic [63:0] owners_buf;
  logic wr_stall;
  logic wr_en, wr_en_evict_way, wr_data_hprot, wr_data_dirty_bit, incr, done;
  logic [3:0] wr_way, wr_data_evict_way, wr_data_owner;
  logic [15:0] wr_rst_flush, wr_data_sharers;
  logic [2:0] wr_data_state;
  logic [19:0] wr_data_tag;
  logic [127:0] wr_data_line;

  logic [2:0]   st [16];
  logic         hp [16];
  logic         dt [16];
  logic [19:0]  tg [16];
  logic [127:0] ln [16];
  logic [15:0]  sh [16];
  logic [3:0]   ow [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      states_buf[i*3 +: 3]       = st[i];
      hprots_buf[i]              = hp[i];
      dirty_bits_buf[i]          = dt[i];
      tags_buf[i*20 +: 20]       = tg[i];
      lines_buf[i*128 +: 128]    = ln[i];
      sharers_buf[i*16 +: 16]    = sh[i];
      owners_buf[i*4 +: 4]       = ow[i];
    end
  end

  llc_update_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_way(req_way), .req_update_evict_way(req_update_evict_way),
    .req_evict_way(req_evict_way),
    .states_buf(states_buf), .hprots_buf(hprots_buf), .dirty_bits_buf(dirty_bits_buf),
    .tags_buf(tags_buf), .lines_buf(lines_buf), .sharers_buf(sharers_buf),
    .owners_buf(owners_buf), .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_way(wr_way), .wr_rst_flush(wr_rst_flush),
    .wr_en_evict_way(wr_en_evict_way),
    .wr_data_state(wr_data_state), .wr_data_tag(wr_data_tag), .wr_data_line(wr_data_line),
    .wr_data_sharers(wr_data_sharers), .wr_data_owner(wr_data_owner),
    .wr_data_evict_way(wr_data_evict_way), .wr_data_hprot(wr_data_hprot),
    .wr_data_dirty_bit(wr_data_dirty_bit),
    .incr_rst_flush_stalled_set(incr), .done(done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic randomize_bufs();
    for (int i = 0; i < 16; i++) begin
      st[i] = 3'($urandom_range(0, 4));
      hp[i] = 1'($urandom);
      dt[i] = 1'($urandom);
      tg[i] = 20'($urandom);
      ln[i] = {$urandom, $urandom, $urandom, $urandom};
      sh[i] = 16'($urandom);
      ow[i] = 4'($urandom);
    end
  endtask

  // vd: VALID/DATA ways, vi: VALID/INSTR ways, sd: SHARED/DATA ways.
  // All remaining ways are INVALID/DATA.
  task automatic set_pattern(input logic [15:0] vd, input logic [15:0] vi, input logic [15:0] sd);
    randomize_bufs();
    for (int i = 0; i < 16; i++) begin
      st[i] = (vd[i] || vi[i]) ? VAL : (sd[i] ? SHR : INV);
      hp[i] = vi[i] ? INSTR : DATA;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] way, input logic uev,
                       input logic [3:0] ev, input logic idle_stall, input string name);
    req_valid = 1'b1; req_op = op; req_way = way;
    req_update_evict_way = uev; req_evict_way = ev; wr_stall = idle_stall;
    sample();
    check({name, "_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0; req_op = OP_NOP; wr_stall = 1'b0;
  endtask

  // Directed sweep table: expected masks for the non-stalled cycles, in order.
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] vd, vi, sd;
    logic [31:0] stall;
    int          cycles;
    logic [63:0] masks;
  } vec_t;

  // Reference model: one entry per non-stalled cycle of a command.
  typedef struct {
    logic         wen;
    logic [3:0]   way;
    logic         ev_en;
    logic [3:0]   ev;
    logic [15:0]  mask;
    logic         sweep;
    logic         last;
    logic [2:0]   st;
    logic [19:0]  tag;
    logic [127:0] line;
    logic [15:0]  sh;
    logic [3:0]   ow;
    logic         hp, dt;
  } step_t;

  task automatic build_model(input logic [1:0] op, input logic [3:0] way, input logic uev,
                             input logic [3:0] ev, output step_t steps[$]);
    step_t s;
    steps = {};
    s = '{default: '0};
    if (op == OP_UPDATE || op == OP_NOP) begin
      s.last = 1'b1;
      if (op == OP_UPDATE) begin
        s.wen = 1'b1; s.way = way; s.ev_en = uev; s.ev = ev;
        s.st = st[way]; s.tag = tg[way]; s.line = ln[way]; s.sh = sh[way];
        s.ow = ow[way]; s.hp = hp[way]; s.dt = dt[way];
      end
      steps.push_back(s);
    end else begin
      for (int grp = 0; grp < 4; grp++) begin
        s = '{default: '0};
        s.sweep = 1'b1;
        s.last  = (grp == 3);
        s.ev_en = s.last && (op == OP_RST);
        s.st    = INV;
        for (int w = grp * 4; w < grp * 4 + 4; w++)
          if (op == OP_RST || (st[w] == VAL && hp[w] == DATA)) s.mask[w] = 1'b1;
        steps.push_back(s);
      end
    end
  endtask

  task automatic run_random(input int n);
    step_t steps[$];
    logic [1:0] op;
    logic [3:0] way, ev;
    logic uev;
    logic [31:0] stall;
    int s, k;
    for (int t = 0; t < n; t++) begin
      randomize_bufs();
      op = 2'($urandom_range(0, 3)); way = 4'($urandom); ev = 4'($urandom); uev = 1'($urandom);
      stall = 32'($urandom) & 32'($urandom) & 32'h0000_0FFF;
      build_model(op, way, uev, ev, steps);
      issue(op, way, uev, ev, 1'($urandom), "rnd");
      randomize_bufs();  // must not affect the accepted command
      s = 0; k = 0;
      while (s < steps.size()) begin
        wr_stall = stall[k];
        sample();
        if (stall[k]) begin
          check("rnd_stall_strobes", {wr_en, wr_en_evict_way, wr_rst_flush, incr, done}, 0);
        end else begin
          check("rnd_wen", wr_en, steps[s].wen);
          if (steps[s].wen) begin
            check("rnd_way", wr_way, steps[s].way);
            check("rnd_state", wr_data_state, steps[s].st);
            check("rnd_tag", wr_data_tag, steps[s].tag);
            check("rnd_line", wr_data_line, steps[s].line);
            check("rnd_sharers", wr_data_sharers, steps[s].sh);
            check("rnd_owner", wr_data_owner, steps[s].ow);
            check("rnd_hprot_dirty", {wr_data_hprot, wr_data_dirty_bit}, {steps[s].hp, steps[s].dt});
          end
          check("rnd_ev_en", wr_en_evict_way, steps[s].ev_en);
          if (steps[s].ev_en) check("rnd_ev", wr_data_evict_way, steps[s].ev);
          check("rnd_mask", wr_rst_flush, steps[s].mask);
          if (steps[s].sweep)
            check("rnd_sweep_data", {wr_data_state, wr_data_dirty_bit, wr_data_sharers}, 0);
          check("rnd_incr", incr, steps[s].last && steps[s].sweep);
          check("rnd_done", done, steps[s].last);
          s++;
        end
        check("rnd_busy_ready", req_ready, 0);
        k++;
        tick();
        wr_stall = 1'b0;
      end
      sample();
      check("rnd_idle_ready", req_ready, 1);
      check("rnd_idle_quiet", {wr_en, wr_rst_flush, done, incr}, 0);
      tick();
    end
  endtask

  initial begin
    vec_t vecs[5];
    logic [15:0] m;
    vecs[0] = '{"rst",        OP_RST,   16'h0000, 16'h0000, 16'h0000, 32'h0, 4, 64'hF000_0F00_00F0_000F};
    vecs[1] = '{"flush_mix",  OP_FLUSH, 16'h0209, 16'h0010, 16'h0080, 32'h0, 4, 64'h0000_0200_0000_0009};
    vecs[2] = '{"rst_stall",  OP_RST,   16'h0000, 16'h0000, 16'h0000, 32'h6, 6, 64'hF000_0F00_00F0_000F};
    vecs[3] = '{"flush_none", OP_FLUSH, 16'h0000, 16'hFFFF, 16'h0000, 32'h0, 4, 64'h0};
    vecs[4] = '{"flush_all",  OP_FLUSH, 16'hFFFF, 16'h0000, 16'h0000, 32'h5, 6, 64'hF000_0F00_00F0_000F};

    rst = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_way = '0;
    req_update_evict_way = 1'b0; req_evict_way = '0; wr_stall = 1'b0;
    randomize_bufs();

    // Reset state
    sample();
    check("reset_ready", req_ready, 1);
    check("reset_strobes", {wr_en, wr_en_evict_way, wr_rst_flush, incr, done}, 0);
    check("reset_data", {wr_data_tag, wr_data_state, wr_data_evict_way, wr_way}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // UPDATE way 5
    st[5] = VAL; tg[5] = 20'hABCDE; dt[5] = 1'b1;
    issue(OP_UPDATE, 4'd5, 1'b1, 4'd7, 1'b0, "upd");
    sample();
    check("upd_wen", wr_en, 1);
    check("upd_way", wr_way, 5);
    check("upd_tag", wr_data_tag, 20'hABCDE);
    check("upd_state", wr_data_state, VAL);
    check("upd_dirty", wr_data_dirty_bit, 1);
    check("upd_ev_en", wr_en_evict_way, 1);
    check("upd_ev", wr_data_evict_way, 7);
    check("upd_done", done, 1);
    check("upd_mask", wr_rst_flush, 0);
    tick();
    sample();
    check("upd_after", {wr_en, wr_en_evict_way, done, req_ready}, 1);
    tick();

    // Table-driven sweeps
    for (int v = 0; v < 5; v++) begin
      int j;
      set_pattern(vecs[v].vd, vecs[v].vi, vecs[v].sd);
      issue(vecs[v].op, 4'd0, 1'b0, 4'd0, 1'b0, vecs[v].name);
      j = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        wr_stall = vecs[v].stall[c];
        sample();
        check({vecs[v].name, "_busy"}, req_ready, 0);
        if (vecs[v].stall[c]) begin
          check({vecs[v].name, "_stall"}, {wr_en_evict_way, wr_rst_flush, incr, done}, 0);
        end else begin
          check({vecs[v].name, "_mask"}, wr_rst_flush, vecs[v].masks[j*16 +: 16]);
          check({vecs[v].name, "_incr"}, incr, j == 3);
          check({vecs[v].name, "_done"}, done, j == 3);
          check({vecs[v].name, "_ev_en"}, wr_en_evict_way, (j == 3) && (vecs[v].op == OP_RST));
          if (j == 3 && vecs[v].op == OP_RST) check({vecs[v].name, "_ev"}, wr_data_evict_way, 0);
          check({vecs[v].name, "_inv"}, {wr_data_state, wr_data_dirty_bit, wr_data_sharers}, 0);
          j++;
        end
        tick();
      end
      wr_stall = 1'b0;
      sample();
      check({vecs[v].name, "_end_ready"}, req_ready, 1);
      check({vecs[v].name, "_end_quiet"}, {wr_rst_flush, incr, done}, 0);
      tick();
    end

    // FLUSH snapshot with buffers changed and a held request
    set_pattern(16'h0209, 16'h0010, 16'h0080);
    req_valid = 1'b1; req_op = OP_FLUSH;
    sample();
    check("snap_ready", req_ready, 1);
    tick();
    req_op = OP_RST;
    for (int i = 0; i < 16; i++) begin st[i] = VAL; hp[i] = DATA; end
    for (int c = 0; c < 4; c++) begin
      m = (c == 0) ? 16'h0009 : ((c == 2) ? 16'h0200 : 16'h0000);
      sample();
      check("snap_busy", req_ready, 0);
      check("snap_mask", wr_rst_flush, m);
      check("snap_done", done, c == 3);
      tick();
    end
    sample();
    check("held_ready", req_ready, 1);
    tick();
    req_valid = 1'b0; req_op = OP_NOP;
    for (int c = 0; c < 4; c++) begin
      m = 16'h000F;
      m = m << (4 * c);
      sample();
      check("held_mask", wr_rst_flush, m);
      check("held_done", done, c == 3);
      tick();
    end

    // Randomized commands against the model
    run_random(60);

    // Async reset in the middle of a sweep
    issue(OP_RST, 4'd0, 1'b0, 4'd0, 1'b0, "arst");
    tick(); tick();
    sample();
    check("arst_g2_mask", wr_rst_flush, 16'h0F00);
    rst = 1'b1;
    #1;
    check("arst_ready", req_ready, 1);
    check("arst_strobes", {wr_en, wr_en_evict_way, wr_rst_flush, incr, done}, 0);
    check("arst_data", {wr_data_state, wr_data_evict_way, wr_data_dirty_bit}, 0);
    #1;
    rst = 1'b0;
    tick();
    randomize_bufs();
    tg[2] = 20'h12345;
    issue(OP_UPDATE, 4'd2, 1'b0, 4'd0, 1'b0, "post_arst");
    sample();
    check("post_arst_wen", {wr_en, wr_way, wr_data_tag}, {1'b1, 4'd2, 20'h12345});
    check("post_arst_quiet", {wr_rst_flush, wr_en_evict_way, incr}, 0);
    check("post_arst_done", done, 1);
    tick();
    sample();
    check("post_arst_idle", {req_ready, wr_rst_flush, done}, {1'b1, 16'h0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
